kiwi_stream_arbiter: RTL and testbench
======================================

# kiwi_stream_arbiter

Round-robin burst scheduler that shares one AXI4-Stream output (toward the DMA/readout path) between the RX FIFO and the waterfall FIFOs of the SDR receiver.
- Grants a source only when its FIFO holds at least one full burst.
- Moves exactly BURST_LEN words per grant, marking the last with tlast.
- Tags each burst with the source index so software can demultiplex RX, WF0 and WF1.

## Interface
Parameters:
- NUM_SRC, 3: number of requesters (index 0 = RX, 1..N-1 = waterfall channels).
- DATA_WIDTH, 32: word width of each source and of the output.
- CNT_WIDTH, 16: width of each FIFO fill-count input.
- BURST_LEN, 16: words per grant; power of two, 2..1024.

Ports:
- aclk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_enable  in  NUM_SRC  per-source enable; a disabled source is never granted.
- s_fill  in  NUM_SRC*CNT_WIDTH  FIFO fill count per source; slice i is bits [i*CNT_WIDTH +: CNT_WIDTH].
- s_axis_tdata  in  NUM_SRC*DATA_WIDTH  source data, packed the same way.
- s_axis_tvalid  in  NUM_SRC  source valid.
- s_axis_tready  out  NUM_SRC  source ready; at most one bit high in any cycle.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  high on the final word of a burst.
- m_axis_tuser  out  $clog2(NUM_SRC)  index of the source currently granted.
- sts_busy  out  1  high while any burst is in progress.
- sts_grants  out  32  total completed bursts; wraps modulo 2^32.

## Operation
- FSM states: IDLE, HEADER (present only when the header feature is compiled in), BURST.
- Eligibility: source i is eligible when cfg_enable[i]=1 and s_fill[i] >= BURST_LEN.
- IDLE:
  - Search for an eligible source, starting at rr_ptr and wrapping modulo NUM_SRC.
  - On a hit, latch grant = found index and word_cnt = 0.
  - Go to HEADER if compiled in, otherwise to BURST.
  - With no eligible source, stay in IDLE.
- BURST:
  - s_axis_tready[grant] = m_axis_tready.
  - m_axis_tvalid = s_axis_tvalid[grant].
  - m_axis_tdata = s_axis_tdata[grant].
  - A transfer is a cycle with m_axis_tvalid and m_axis_tready both high; word_cnt increments on each transfer.
  - m_axis_tlast = (word_cnt == BURST_LEN-1).
  - On the tlast transfer: rr_ptr = (grant+1) mod NUM_SRC, sts_grants increments, FSM returns to IDLE.
- cfg_enable falling mid-burst does not abort; the burst completes.
- Drops in s_fill mid-burst are ignored.
- m_axis_tuser equals grant in HEADER and BURST, and 0 in IDLE.
- sts_busy = (state != IDLE).

## Timing
- Reset values: state IDLE, rr_ptr 0, grant 0, word_cnt 0, sts_grants 0, all s_axis_tready 0, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tuser 0, sts_busy 0.
- Reset asserted mid-burst: every output is at its reset value in the cycle after the reset edge. The partial burst is abandoned; the upstream FIFO keeps the words not yet transferred.
- Arbitration latency: an eligible source seen in IDLE at edge k gives m_axis_tvalid at the earliest in cycle k+1.
- Header word occupies one cycle in addition to the burst.
- Data path in BURST is combinational pass-through with zero added latency. At 100% ready and valid, throughput is BURST_LEN words per BURST_LEN+1 cycles (BURST_LEN+2 with header).
- Back-to-back: IDLE always lasts at least one cycle between bursts.
- Several sources eligible together: the first one found at or after rr_ptr wins. No source waits more than NUM_SRC-1 bursts.
- s_fill is sampled only in IDLE.

## Configuration
- Macro: KIWI_ARB_HEADER_EN.
- Defined:
  - HEADER state emits one word before each burst: {8'hA5, 8'(grant), 16'(seq[grant])}, zero-extended or truncated to DATA_WIDTH.
  - seq is a 16-bit per-source counter. It increments when the header transfers, wraps at 0xFFFF -> 0 and resets to 0.
  - No source tready is asserted during HEADER.
  - m_axis_tlast is 0 on the header word.
- Undefined: IDLE goes directly to BURST; there is no seq storage and no header word.

## Structure
- Package kiwi_arb_pkg holds:
  - the state enum (IDLE, HEADER, BURST);
  - the header magic constant 8'hA5;
  - a function for the round-robin next-index search.
- One sub-module, kiwi_rr_picker: a combinational pick of the first set bit at or after a pointer, with a found flag. It is reusable by other Kiwi arbiters.

## Test plan
- Single source: NUM_SRC=3, BURST_LEN=16, only source 1 enabled with s_fill=16, data 0..15 -> 16 output words 0..15, tuser=1, tlast on word 15, sts_grants=1.
- Fairness: all sources enabled, fill held at 64, 9 bursts -> grant order 0,1,2,0,1,2,0,1,2, sts_grants=9.
- Threshold: source 0 fill=15 -> no grant for 100 cycles. Raise fill to 16 -> m_axis_tvalid high within 2 cycles.
- Backpressure: m_axis_tready toggles 1,0 each cycle -> data order preserved, s_axis_tready mirrors m_axis_tready, 16 transfers total.
- Reset mid-burst: assert reset after word 7 -> next cycle m_axis_tvalid=0 and rr_ptr=0. A new burst then starts at source 0 with word_cnt=0.
- Header (KIWI_ARB_HEADER_EN defined): two bursts from source 2 -> header words 0xA5020000 then 0xA5020001, each followed by 16 data words.

Source files
------------

// File: rtl/kiwi_arb_pkg.sv
// Shared types, constants and helpers for the Kiwi stream arbiters.
// The optional header word (KIWI_ARB_HEADER_EN) uses HDR_MAGIC; the HEADER
// state is always declared so every build shares one state encoding.
package kiwi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    BURST  = 2'd2
  } arb_state_e;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  // Widest request vector the round-robin search accepts.
  localparam int RR_MAX_SRC = 32;

  // Index of the first set bit in req[0..n-1] at or after ptr, wrapping
  // modulo n. found is cleared when no bit is set.
  function automatic int rr_search(input logic [RR_MAX_SRC-1:0] req,
                                   input int ptr,
                                   input int n,
                                   output logic found);
    int cand;
    found     = 1'b0;
    rr_search = 0;
    for (int k = 0; k < RR_MAX_SRC; k++) begin
      if (k < n && !found) begin
        cand = ptr + k;
        if (cand >= n) begin
          cand = cand - n;
        end
        if (req[cand[4:0]]) begin
          found     = 1'b1;
          rr_search = cand;
        end
      end
    end
  endfunction

endpackage

// File: rtl/kiwi_rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping around N entries. Reusable by any Kiwi arbiter with N <= 32.
module kiwi_rr_picker
  import kiwi_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [RR_MAX_SRC-1:0] req_ext;
  logic                  hit;
  int                    pick;

  // Widen the request vector to the helper's fixed width and search it.
  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    hit            = 1'b0;
    pick           = rr_search(req_ext, int'(ptr), N, hit);
    found          = hit;
    idx            = IW'(pick);
  end

endmodule

// File: rtl/kiwi_stream_arbiter.sv
// Round-robin burst scheduler sharing one AXI4-Stream output between the
// RX FIFO (source 0) and the waterfall FIFOs. A source is granted only when
// it holds a full burst; each grant moves BURST_LEN words, the last with
// tlast, and tuser carries the granted index.
// Optional: define KIWI_ARB_HEADER_EN to prefix each burst with a header
// word {A5, source, per-source sequence number}.
module kiwi_stream_arbiter
  import kiwi_arb_pkg::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int BURST_LEN  = 16
) (
  input  logic                          aclk,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            cfg_enable,
  input  logic [NUM_SRC*CNT_WIDTH-1:0]  s_fill,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [$clog2(NUM_SRC)-1:0]    m_axis_tuser,
  output logic                          sts_busy,
  output logic [31:0]                   sts_grants
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int WC_W  = $clog2(BURST_LEN);

  arb_state_e             state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       grant;
  logic [WC_W-1:0]        word_cnt;
  logic [NUM_SRC-1:0]     eligible;
  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic                   sel_valid;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   word_last;
  logic                   data_xfer;

`ifdef KIWI_ARB_HEADER_EN
  logic [15:0]            seq [NUM_SRC];
  logic [15:0]            sel_seq;
  logic [31:0]            hdr_word;
`endif

  // A source may be granted only when enabled and holding a whole burst.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = cfg_enable[i] &&
                    (s_fill[i*CNT_WIDTH +: CNT_WIDTH] >= CNT_WIDTH'(BURST_LEN));
    end
  end

  kiwi_rr_picker #(
    .N  (NUM_SRC),
    .IW (IDX_W)
  ) u_picker (
    .req   (eligible),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Select the granted source's stream signals (and its header sequence).
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
`ifdef KIWI_ARB_HEADER_EN
    sel_seq   = '0;
`endif
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant == IDX_W'(i)) begin
        sel_valid = s_axis_tvalid[i];
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef KIWI_ARB_HEADER_EN
        sel_seq   = seq[i];
`endif
      end
    end
  end

`ifdef KIWI_ARB_HEADER_EN
  assign hdr_word = {HDR_MAGIC, 8'(grant), sel_seq};
`endif

  assign word_last = (word_cnt == WC_W'(BURST_LEN - 1));
  assign data_xfer = (state == BURST) && sel_valid && m_axis_tready;
  assign sts_busy  = (state != IDLE);

  // Output stage: zero-latency pass-through of the granted source in BURST.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    s_axis_tready = '0;
    case (state)
      BURST: begin
        m_axis_tvalid = sel_valid;
        m_axis_tdata  = sel_data;
        m_axis_tlast  = word_last;
        m_axis_tuser  = grant;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (grant == IDX_W'(i)) begin
            s_axis_tready[i] = m_axis_tready;
          end
        end
      end
`ifdef KIWI_ARB_HEADER_EN
      HEADER: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = DATA_WIDTH'(hdr_word);
        m_axis_tuser  = grant;
      end
`endif
      default: begin
      end
    endcase
  end

  // Arbitration FSM: pick in IDLE, optionally emit a header, count a burst.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      word_cnt   <= '0;
      sts_grants <= '0;
`ifdef KIWI_ARB_HEADER_EN
      for (int i = 0; i < NUM_SRC; i++) begin
        seq[i] <= '0;
      end
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant    <= pick_idx;
            word_cnt <= '0;
`ifdef KIWI_ARB_HEADER_EN
            state    <= HEADER;
`else
            state    <= BURST;
`endif
          end
        end
`ifdef KIWI_ARB_HEADER_EN
        HEADER: begin
          if (m_axis_tready) begin
            for (int i = 0; i < NUM_SRC; i++) begin
              if (grant == IDX_W'(i)) begin
                seq[i] <= seq[i] + 16'd1;
              end
            end
            state <= BURST;
          end
        end
`endif
        BURST: begin
          if (data_xfer) begin
            word_cnt <= word_cnt + WC_W'(1);
            if (word_last) begin
              rr_ptr     <= (grant == IDX_W'(NUM_SRC - 1)) ? '0 : grant + IDX_W'(1);
              sts_grants <= sts_grants + 32'd1;
              state      <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kiwi_stream_arbiter.sv
// Scoreboard bench for kiwi_stream_arbiter (NUM_SRC=3, BURST_LEN=16).
// Works in both builds; define KIWI_ARB_HEADER_EN to expect header words.
module tb_kiwi_stream_arbiter;

  localparam int NUM_SRC = 3;
  localparam int DW      = 32;
  localparam int CW      = 16;
  localparam int BL      = 16;
`ifdef KIWI_ARB_HEADER_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [1:0]  user;
  } exp_t;

  logic                    aclk;
  logic                    reset;
  logic [NUM_SRC-1:0]      cfg_enable;
  logic [NUM_SRC*CW-1:0]   s_fill;
  logic [NUM_SRC*DW-1:0]   s_axis_tdata;
  logic [NUM_SRC-1:0]      s_axis_tvalid;
  logic [NUM_SRC-1:0]      s_axis_tready;
  logic [DW-1:0]           m_axis_tdata;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  logic                    m_axis_tlast;
  logic [1:0]              m_axis_tuser;
  logic                    sts_busy;
  logic [31:0]             sts_grants;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   idx [NUM_SRC];
  int   lim [NUM_SRC];
  int   extra [NUM_SRC];
  int   exp_idx [NUM_SRC];
  int   exp_seq [NUM_SRC];

  kiwi_stream_arbiter #(
    .NUM_SRC    (NUM_SRC),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW),
    .BURST_LEN  (BL)
  ) dut (
    .aclk          (aclk),
    .reset         (reset),
    .cfg_enable    (cfg_enable),
    .s_fill        (s_fill),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .sts_busy      (sts_busy),
    .sts_grants    (sts_grants)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Source FIFO model: words idx..lim-1 are available, data = src<<16 | idx.
  always_comb begin
    s_fill        = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s_fill[i*CW +: CW]       = 16'(lim[i] - idx[i] + extra[i]);
      s_axis_tvalid[i]         = (idx[i] < lim[i]);
      s_axis_tdata[i*DW +: DW] = (32'(i) << 16) + 32'(idx[i]);
    end
  end

  // Source FIFOs pop the words handed over at each rising edge.
  initial begin
    logic [NUM_SRC-1:0] took;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx[i] = 0; lim[i] = 0; extra[i] = 0; exp_idx[i] = 0; exp_seq[i] = 0;
    end
    forever begin
      @(negedge aclk);
      took = s_axis_tready & s_axis_tvalid;
      @(posedge aclk);
      #1;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (took[i]) idx[i] = idx[i] + 1;
      end
    end
  end

  // Monitor: every output handshake pops and checks one expected word.
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      if (!reset && m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_word: got data 0x%0h last %0b user %0d, none expected",
                   m_axis_tdata, m_axis_tlast, m_axis_tuser);
        end else begin
          e = exp_q.pop_front();
          if ({m_axis_tdata, m_axis_tlast, m_axis_tuser} !== e) begin
            errors++;
            $display("[TB] FAIL out_word: got data 0x%0h last %0b user %0d, expected data 0x%0h last %0b user %0d",
                     m_axis_tdata, m_axis_tlast, m_axis_tuser, e.data, e.last, e.user);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  // Queue the expected output of one grant: optional header, then data words.
  task automatic pushBurst(input int src, input int nwords);
    exp_t e;
`ifdef KIWI_ARB_HEADER_EN
    e.data = {8'hA5, 8'(src), 16'(exp_seq[src])};
    e.last = 1'b0;
    e.user = 2'(src);
    exp_q.push_back(e);
    exp_seq[src] = exp_seq[src] + 1;
`endif
    for (int k = 0; k < nwords; k++) begin
      e.data = (32'(src) << 16) + 32'(exp_idx[src] + k);
      e.last = (k == BL - 1);
      e.user = 2'(src);
      exp_q.push_back(e);
    end
    exp_idx[src] = exp_idx[src] + nwords;
  endtask

  task automatic waitGrants(input string name, input int target);
    int n = 0;
    while (sts_grants != 32'(target) && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    checkOutput(name, 64'(sts_grants), 64'(target));
    tick();
    tick();
    checkOutput({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    checkOutput({name, "_sready"}, 64'(s_axis_tready), 64'd0);
    checkOutput({name, "_tlast"},  64'(m_axis_tlast),  64'd0);
    checkOutput({name, "_tuser"},  64'(m_axis_tuser),  64'd0);
    checkOutput({name, "_busy"},   64'(sts_busy),      64'd0);
  endtask

  task automatic applyStimulus();
    int n;
    int cnt;
    int bad;
    int rdy_hi;
    int hdr_rdy;

    // Reset state.
    reset = 1'b1; cfg_enable = '0; m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checkIdleOutputs("reset");
    checkOutput("reset_grants", 64'(sts_grants), 64'd0);
    tick();
    reset = 1'b0;

    // Fairness: all full, three bursts each, order 0,1,2,0,1,2,0,1,2.
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < NUM_SRC; s++) pushBurst(s, BL);
    end
    for (int s = 0; s < NUM_SRC; s++) lim[s] = idx[s] + 3 * BL;
    cfg_enable = 3'b111;
    waitGrants("fair_grants", 9);

    // Single source 1.
    pushBurst(1, BL);
    cfg_enable = 3'b010;
    lim[1] = idx[1] + BL;
    waitGrants("single_grants", 10);

    // Backpressure on source 2: ready toggles every cycle.
    pushBurst(2, BL);
    cfg_enable = 3'b100;
    lim[2] = idx[2] + BL;
    n = 0; bad = 0; rdy_hi = 0; hdr_rdy = 0;
    m_axis_tready = 1'b1;
    while (sts_grants != 32'd11 && n < 400) begin
      @(negedge aclk);
      if (s_axis_tready[2] && !m_axis_tready) bad++;
      if (s_axis_tready[1:0] != 2'b00) bad++;
      if (s_axis_tready[2] && m_axis_tready) rdy_hi++;
      if (sts_busy && m_axis_tready && !s_axis_tready[2]) hdr_rdy++;
      tick();
      m_axis_tready = !m_axis_tready;
      n++;
    end
    m_axis_tready = 1'b1;
    checkOutput("bp_ready_mirror", 64'(bad), 64'd0);
    checkOutput("bp_data_transfers", 64'(rdy_hi), 64'(BL));
    checkOutput("bp_header_cycles", 64'(hdr_rdy), 64'(HDR_WORDS));
    waitGrants("bp_grants", 11);

    // Threshold: 15 words never granted, 16 granted within two cycles.
    cfg_enable = 3'b001;
    lim[0] = idx[0] + BL - 1;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge aclk);
      if (m_axis_tvalid || sts_busy) cnt++;
    end
    checkOutput("thr_below_idle_cycles", 64'(cnt), 64'd0);
    pushBurst(0, BL);
    tick();
    lim[0] = lim[0] + 1;
    n = 0;
    while (!m_axis_tvalid && n < 2) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("thr_tvalid_latency", 64'(m_axis_tvalid), 64'd1);
    waitGrants("thr_grants", 12);

    // Reset mid-burst: source 1 supplies only 8 of 16 words, then reset.
    pushBurst(1, 8);
    cfg_enable = 3'b010;
    extra[1] = 8;
    lim[1] = idx[1] + 8;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("partial_drained", 64'(exp_q.size()), 64'd0);
    tick();
    @(negedge aclk);
    checkOutput("partial_stalled_busy", 64'(sts_busy), 64'd1);
    checkOutput("partial_stalled_tvalid", 64'(m_axis_tvalid), 64'd0);
    tick();
    reset = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    checkIdleOutputs("midreset");
    checkOutput("midreset_grants", 64'(sts_grants), 64'd0);
    tick();
    reset = 1'b0;
    extra[1] = 0;
    for (int s = 0; s < NUM_SRC; s++) exp_seq[s] = 0;

    // After reset rr_ptr is 0: source 0 wins over source 1.
    pushBurst(0, BL);
    pushBurst(1, BL);
    lim[0] = idx[0] + BL;
    lim[1] = idx[1] + BL;
    cfg_enable = 3'b011;
    waitGrants("post_reset_grants", 2);

    // Two bursts from source 2 (header sequence 0 then 1 when enabled).
    pushBurst(2, BL);
    pushBurst(2, BL);
    cfg_enable = 3'b100;
    lim[2] = idx[2] + 2 * BL;
    waitGrants("src2_grants", 4);
  endtask

  initial begin
    applyStimulus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
